// File: rtl/mul16_seq_ctrl.sv
// 16x16 multiply sequencer time-sharing one external 8x8 unsigned engine.
// Sign-magnitude handling: magnitudes in, conditional negate in FIX.
module mul16_seq_ctrl #(
  parameter bit SIGNED  = 1'b1,
  parameter int MUL_LAT = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [7:0]  mul_a,
  output logic [7:0]  mul_b,
  input  logic [15:0] mul_y,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] y,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL0,
    S_MUL1,
    S_MUL2,
    S_MUL3,
    S_FIX,
    S_DONE
  } state_t;

  localparam logic [1:0] LAST = 2'(MUL_LAT);

  state_t      state;
  state_t      state_nx;
  logic [1:0]  cnt;
  logic [15:0] ma;
  logic [15:0] mb;
  logic [15:0] a_abs;
  logic [15:0] b_abs;
  logic        neg;
  logic [31:0] acc;
  logic [31:0] part;
  logic        accept;
  logic        is_mul;
  logic        step_end;

  assign in_ready  = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign out_valid = (state == S_DONE);
  assign accept    = in_valid && (state == S_IDLE);
  assign is_mul    = state inside {S_MUL0, S_MUL1, S_MUL2, S_MUL3};
  assign step_end  = (cnt == LAST);

  // 0x8000 negates to itself, which is the correct 16-bit magnitude
  assign a_abs = (SIGNED && a[15]) ? -a : a;
  assign b_abs = (SIGNED && b[15]) ? -b : b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: if (in_valid) state_nx = S_MUL0;
      S_MUL0: if (step_end) state_nx = S_MUL1;
      S_MUL1: if (step_end) state_nx = S_MUL2;
      S_MUL2: if (step_end) state_nx = S_MUL3;
      S_MUL3: if (step_end) state_nx = S_FIX;
      S_FIX:  state_nx = S_DONE;
      S_DONE: if (out_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    part = '0;
    unique case (state)
      S_MUL0:         part = {16'b0, mul_y};
      S_MUL1, S_MUL2: part = {8'b0, mul_y, 8'b0};
      S_MUL3:         part = {mul_y, 16'b0};
      default:        part = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      ma    <= '0;
      mb    <= '0;
      neg   <= 1'b0;
      acc   <= '0;
      mul_a <= '0;
      mul_b <= '0;
      y     <= '0;
    end else begin
      cnt <= (is_mul && !step_end) ? cnt + 2'd1 : 2'd0;
      if (accept) begin
        ma    <= a_abs;
        mb    <= b_abs;
        neg   <= SIGNED & (a[15] ^ b[15]);
        acc   <= '0;
        mul_a <= a_abs[7:0];
        mul_b <= b_abs[7:0];
      end
      if (is_mul && step_end) begin
        acc <= acc + part;
        unique case (state)
          S_MUL0: begin
            mul_a <= ma[7:0];
            mul_b <= mb[15:8];
          end
          S_MUL1: begin
            mul_a <= ma[15:8];
            mul_b <= mb[7:0];
          end
          S_MUL2: begin
            mul_a <= ma[15:8];
            mul_b <= mb[15:8];
          end
          default: ;
        endcase
      end
      if (state == S_FIX) y <= neg ? -acc : acc;
    end
  end

endmodule

// File: tb/tb_mul16_seq_ctrl.sv
// Bench for mul16_seq_ctrl: four instances covering SIGNED x MUL_LAT {0,2}.
// Expected products are queued at accept and popped when out_valid rises.
module tb_mul16_seq_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid  [4];
  logic        in_ready  [4];
  logic        out_valid [4];
  logic        out_ready [4];
  logic        busy      [4];
  logic [15:0] a         [4];
  logic [15:0] b         [4];
  logic [15:0] mul_y     [4];
  logic [7:0]  mul_a     [4];
  logic [7:0]  mul_b     [4];
  logic [31:0] y         [4];

  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];

  for (genvar g = 0; g < 4; g++) begin : gen_dut
    localparam bit SG = (g % 2) == 1;
    localparam int LT = (g >= 2) ? 2 : 0;
    mul16_seq_ctrl #(.SIGNED(SG), .MUL_LAT(LT)) u_dut (
      .clk(clk),
      .rst_n(rst_n),
      .in_valid(in_valid[g]),
      .in_ready(in_ready[g]),
      .a(a[g]),
      .b(b[g]),
      .mul_a(mul_a[g]),
      .mul_b(mul_b[g]),
      .mul_y(mul_y[g]),
      .out_valid(out_valid[g]),
      .out_ready(out_ready[g]),
      .y(y[g]),
      .busy(busy[g])
    );
    if (LT == 0) begin : g_comb
      assign mul_y[g] = {8'b0, mul_a[g]} * {8'b0, mul_b[g]};
    end else begin : g_pipe
      logic [15:0] p1;
      logic [15:0] p2;
      always @(posedge clk) begin
        p1 <= {8'b0, mul_a[g]} * {8'b0, mul_b[g]};
        p2 <= p1;
      end
      assign mul_y[g] = p2;
    end
  end

  function automatic logic [31:0] golden(int d, logic [15:0] x, logic [15:0] z);
    if (d % 2 == 1) begin
      int sx;
      int sz;
      sx = int'($signed(x));
      sz = int'($signed(z));
      return 32'(sx * sz);
    end
    return {16'b0, x} * {16'b0, z};
  endfunction

  task automatic accept_op(int d, logic [15:0] x, logic [15:0] z, bit push);
    @(negedge clk);
    n_chk++;
    if (in_ready[d] !== 1'b1) begin
      n_fail++;
      $display("FAIL accept_ready d=%0d got %b want 1", d, in_ready[d]);
    end
    in_valid[d] = 1'b1;
    a[d] = x;
    b[d] = z;
    @(posedge clk);
    #1;
    in_valid[d] = 1'b0;
    a[d] = 16'($urandom);
    b[d] = 16'($urandom);
    if (push) exp_q.push_back(golden(d, x, z));
  endtask

  task automatic wait_out(int d, int exp_lat);
    int lat;
    bit seen;
    logic [31:0] e;
    lat = 0;
    seen = 1'b0;
    while (lat < 60 && !seen) begin
      @(posedge clk);
      #1;
      lat++;
      if (out_valid[d] === 1'b1) seen = 1'b1;
    end
    n_chk++;
    if (!seen) begin
      n_fail++;
      $display("FAIL out_timeout d=%0d got no out_valid want lat %0d", d, exp_lat);
    end else if (lat != exp_lat) begin
      n_fail++;
      $display("FAIL latency d=%0d got %0d want %0d", d, lat, exp_lat);
    end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx;
    n_chk++;
    if (y[d] !== e) begin
      n_fail++;
      $display("FAIL product d=%0d got %h want %h", d, y[d], e);
    end
  endtask

  task automatic do_op(int d, logic [15:0] x, logic [15:0] z, int lat);
    accept_op(d, x, z, 1'b1);
    wait_out(d, lat);
    @(posedge clk);
    #1;
    n_chk++;
    if (out_valid[d] !== 1'b0 || in_ready[d] !== 1'b1) begin
      n_fail++;
      $display("FAIL pulse_end d=%0d got ov=%b ir=%b want ov=0 ir=1",
               d, out_valid[d], in_ready[d]);
    end
  endtask

  task automatic check_reset_vals(int d, string tag);
    n_chk++;
    if (in_ready[d] !== 1'b1 || out_valid[d] !== 1'b0 || busy[d] !== 1'b0 ||
        y[d] !== 32'h0 || mul_a[d] !== 8'h0 || mul_b[d] !== 8'h0) begin
      n_fail++;
      $display("FAIL %s d=%0d got ir=%b ov=%b busy=%b y=%h ma=%h mb=%h want 1 0 0 0 0 0",
               tag, d, in_ready[d], out_valid[d], busy[d], y[d], mul_a[d], mul_b[d]);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    for (int d = 0; d < 4; d++) check_reset_vals(d, "reset_state");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_unsigned;
    do_op(0, 16'h1234, 16'h5678, 5);
    do_op(0, 16'hFFFF, 16'hFFFF, 5);
    do_op(0, 16'h8000, 16'h0002, 5);
  endtask

  task automatic test_signed;
    do_op(1, 16'hFFFD, 16'h0007, 5);
    do_op(1, 16'h8000, 16'h8000, 5);
    do_op(1, 16'h8000, 16'h0001, 5);
    do_op(1, 16'hFFFF, 16'hFFFF, 5);
  endtask

  task automatic test_sequence;
    logic [7:0] ea [4];
    logic [7:0] eb [4];
    ea = '{8'hB2, 8'hB2, 8'hA1, 8'hA1};
    eb = '{8'hD4, 8'hC3, 8'hD4, 8'hC3};
    accept_op(0, 16'hA1B2, 16'hC3D4, 1'b1);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      n_chk++;
      if (mul_a[0] !== ea[k] || mul_b[0] !== eb[k]) begin
        n_fail++;
        $display("FAIL seq_step%0d got %h,%h want %h,%h",
                 k, mul_a[0], mul_b[0], ea[k], eb[k]);
      end
    end
    wait_out(0, 2);
    n_chk++;
    if (mul_a[0] !== 8'hA1 || mul_b[0] !== 8'hC3) begin
      n_fail++;
      $display("FAIL seq_hold got %h,%h want a1,c3", mul_a[0], mul_b[0]);
    end
    @(posedge clk);
    #1;
    do_op(1, 16'h0000, 16'h8001, 5);
    do_op(0, 16'h0000, 16'hFFFF, 5);
  endtask

  task automatic test_backpressure;
    logic [31:0] y_hold;
    out_ready[1] = 1'b0;
    accept_op(1, 16'h0123, 16'hFF00, 1'b1);
    wait_out(1, 5);
    y_hold = golden(1, 16'h0123, 16'hFF00);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid[1] = i[0];
      a[1] = 16'($urandom);
      b[1] = 16'($urandom);
      @(posedge clk);
      #1;
      n_chk++;
      if (out_valid[1] !== 1'b1 || y[1] !== y_hold || in_ready[1] !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold%0d got ov=%b y=%h ir=%b want 1 %h 0",
                 i, out_valid[1], y[1], in_ready[1], y_hold);
      end
    end
    @(negedge clk);
    in_valid[1] = 1'b0;
    out_ready[1] = 1'b1;
    @(posedge clk);
    #1;
    n_chk++;
    if (out_valid[1] !== 1'b0 || in_ready[1] !== 1'b1 || busy[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_release got ov=%b ir=%b busy=%b want 0 1 0",
               out_valid[1], in_ready[1], busy[1]);
    end
  endtask

  task automatic test_reset_mid;
    bit saw;
    accept_op(1, 16'h1111, 16'h2222, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals(1, "reset_mid");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    saw = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid[1] === 1'b1) saw = 1'b1;
    end
    n_chk++;
    if (saw) begin
      n_fail++;
      $display("FAIL reset_discard got out_valid=1 want 0");
    end
    do_op(1, 16'h0002, 16'h0003, 5);
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 4; i++)
      do_op(i % 2, 16'($urandom), 16'($urandom), 5);
  endtask

  task automatic test_lat2_random;
    for (int d = 2; d < 4; d++) begin
      do_op(d, 16'h8000, 16'h8000, 13);
      do_op(d, 16'h8000, 16'h0001, 13);
      do_op(d, 16'hFFFF, 16'hFFFF, 13);
      do_op(d, 16'h0000, 16'h8000, 13);
      for (int i = 0; i < 1000; i++)
        do_op(d, 16'($urandom), 16'($urandom), 13);
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 4; d++) begin
      in_valid[d] = 1'b0;
      out_ready[d] = 1'b1;
      a[d] = '0;
      b[d] = '0;
    end
    test_reset();
    test_unsigned();
    test_signed();
    test_sequence();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_lat2_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
